// File: rtl/mux_pkg.sv
// Shared types for the N:1 registered scan multiplexer: FSM state encoding and mode constants.
package mux_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAN  = 2'd1,
      SCAN = 2'd2
   } state_e;

   localparam logic MODE_MAN  = 1'b0;
   localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/mux_scan_ptr.sv
// Round-robin scan pointer with per-channel dwell counter, wrap and enabled-channel skipping.
// ptr_c is the channel a capture on the coming edge uses (entry clear and masked-channel skip applied).
module mux_scan_ptr #(
   parameter  int unsigned N     = 4,
   parameter  int unsigned DWELL = 1,
   localparam int unsigned SEL_W = $clog2(N),
   localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             clear_in,
   input  logic             step_in,
   input  logic [N-1:0]     mask_in,
   output logic [SEL_W-1:0] ptr_c
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

   logic [SEL_W-1:0] ptr_q, ptr_d, base_c, first_c;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base_c, cnt_c;
   logic             cur_en_c;

   // Next enabled channel above cur, wrapping to the lowest enabled one; cur if none other.
   function automatic logic [SEL_W-1:0] next_en(input logic [SEL_W-1:0] cur,
                                                input logic [N-1:0]     m);
      logic [SEL_W-1:0] r;
      logic             hi;
      r  = cur;
      hi = 1'b0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         if (m[k] && (SEL_W'(k) > cur)) begin
            r  = SEL_W'(k);
            hi = 1'b1;
         end
      end
      if (!hi) begin
         for (int k = int'(N) - 1; k >= 0; k--) begin
            if (m[k]) r = SEL_W'(k);
         end
      end
      return r;
   endfunction

   always_comb begin
      first_c = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         if (mask_in[k]) first_c = SEL_W'(k);
      end
      base_c     = clear_in ? first_c : ptr_q;
      cnt_base_c = clear_in ? '0 : cnt_q;

      cur_en_c = 1'b0;
      for (int k = 0; k < int'(N); k++) begin
         if (base_c == SEL_W'(k)) cur_en_c = mask_in[k];
      end

      ptr_c = base_c;
      cnt_c = cnt_base_c;
      if (!cur_en_c) begin
         ptr_c = next_en(base_c, mask_in);
         cnt_c = '0;
      end

      ptr_d = base_c;
      cnt_d = cnt_base_c;
      if (step_in) begin
         if (cnt_c == LAST) begin
            cnt_d = '0;
            ptr_d = next_en(ptr_c, mask_in);
         end else begin
            cnt_d = cnt_c + 1'b1;
            ptr_d = ptr_c;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mux_nx1_scan.sv
// Registered N:1 mux with manual select or round-robin scan, valid/ready output beat.
// Define MUX_SCAN_MASK_EN to add mask_in, restricting scan to enabled channels.
module mux_nx1_scan
   import mux_pkg::*;
#(
   parameter  int unsigned N     = 4,
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DWELL = 1,
   localparam int unsigned SEL_W = $clog2(N)
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               en_in,
   input  logic               mode_in,
   input  logic [SEL_W-1:0]   sel_in,
   input  logic [N*WIDTH-1:0] data_in,
   input  logic               ready_in,
   output logic [WIDTH-1:0]   y_out,
   output logic [SEL_W-1:0]   ch_out,
   output logic               valid_out,
   output logic               err_out
`ifdef MUX_SCAN_MASK_EN
   ,
   input  logic [N-1:0]       mask_in
`endif
);

   localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] y_q, y_d, word_c;
   logic [SEL_W-1:0] ch_q, ch_d, ch_sel_c, ptr_c;
   logic             valid_q, valid_d, err_q, err_d;
   logic             load_c, clear_c, scan_cap_c, cap_c, step_c, oor_c, any_en_c;
   logic [N-1:0]     mask_c;

`ifdef MUX_SCAN_MASK_EN
   assign mask_c = mask_in;
`else
   assign mask_c = '1;
`endif

   always_comb begin
      state_d = IDLE;
      if (en_in) state_d = (mode_in == MODE_SCAN) ? SCAN : MAN;
   end

   // Capture control; an empty scan mask behaves like IDLE for the output beat.
   assign any_en_c   = |mask_c;
   assign load_c     = !valid_q || ready_in;
   assign clear_c    = (state_d == SCAN) && (state_q != SCAN);
   assign scan_cap_c = (state_d == SCAN) && any_en_c;
   assign cap_c      = load_c && ((state_d == MAN) || scan_cap_c);
   assign step_c     = load_c && scan_cap_c;

   mux_scan_ptr #(
      .N     (N),
      .DWELL (DWELL)
   ) u_ptr (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .clear_in (clear_c),
      .step_in  (step_c),
      .mask_in  (mask_c),
      .ptr_c    (ptr_c)
   );

   always_comb begin
      ch_sel_c = (state_d == MAN) ? sel_in : ptr_c;
      oor_c    = (state_d == MAN) && ({1'b0, sel_in} >= N_LIM);
      word_c   = '0;
      for (int k = 0; k < int'(N); k++) begin
         if (ch_sel_c == SEL_W'(k)) word_c = data_in[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      y_d     = y_q;
      ch_d    = ch_q;
      valid_d = valid_q;
      err_d   = err_q;
      if (load_c) begin
         valid_d = cap_c;
         if (cap_c) begin
            y_d   = oor_c ? '0 : word_c;
            ch_d  = ch_sel_c;
            err_d = oor_c;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         y_q     <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign y_out     = y_q;
   assign ch_out    = ch_q;
   assign valid_out = valid_q;
   assign err_out   = err_q;

endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
Parametrised, registered N-channel, WIDTH-bit multiplexer; successor to the team's fixed 4:1 select muxes. Supports two modes:
- Manual: channel chosen by sel_in.
- Scan: internal pointer steps through channels round-robin, holding each channel DWELL beats.
Output is one registered beat with valid/ready handshake. Sits between sampled data sources and a single downstream consumer (serialiser, logger).

Parameters:
N, 4, number of input channels (>=2; need not be a power of two)
WIDTH, 8, bits per channel
DWELL, 1, beats emitted per channel before the scan pointer advances (>=1)
SEL_W, $clog2(N), derived localparam; width of sel_in/ch_out; not overridable

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_n_in  input  1  asynchronous, active-low reset
en_in  input  1  capture enable
mode_in  input  1  0 = manual, 1 = scan
sel_in  input  SEL_W  manual channel select
data_in  input  N*WIDTH  packed channels; channel k = data_in[k*WIDTH +: WIDTH]
ready_in  input  1  downstream ready
y_out  output  WIDTH  selected data beat
ch_out  output  SEL_W  channel index of y_out
valid_out  output  1  beat valid
err_out  output  1  beat carries an out-of-range manual select

Behaviour:
- Reset (async assert, sync release): y_out=0, ch_out=0, valid_out=0, err_out=0, FSM=IDLE, scan ptr=0, dwell cnt=0.
- FSM states IDLE, MAN, SCAN; evaluated every cycle:
  - en_in=0 -> IDLE.
  - en_in=1, mode_in=0 -> MAN.
  - en_in=1, mode_in=1 -> SCAN.
  - Any entry into SCAN from another state clears ptr and dwell cnt to 0 on that edge.
- Accept condition: load = (!valid_out || ready_in).
- Capture:
  - Occurs on an edge where load=1 and next state is MAN or SCAN.
  - Registers y_out, ch_out, err_out and sets valid_out=1.
  - Latency: input sampled at edge t appears on outputs after edge t.
- Hold: if valid_out=1 and ready_in=0, y_out/ch_out/err_out/valid_out hold, regardless of en_in, mode_in, sel_in or data_in changes.
- Drain: if load=1 and the FSM is going to IDLE, valid_out clears; y_out/ch_out keep their last values.
- MAN capture:
  - ch = sel_in.
  - If sel_in >= N: y_out=0, ch_out=sel_in, err_out=1.
  - Otherwise err_out=0.
- SCAN capture:
  - ch = ptr; err_out=0.
  - On each capture, dwell cnt increments.
  - When dwell cnt = DWELL-1 it clears and ptr advances; wrap N-1 -> 0.
  - No capture (stall or IDLE) -> ptr and dwell cnt frozen.
- Mode change while a beat is held: the held beat completes unchanged; the new mode applies to the next capture.
- Full throughput: ready_in held at 1 gives one beat per cycle.

Optional Feature:
MUX_SCAN_MASK_EN
- Defined:
  - Adds input mask_in[N-1:0]; 1 = channel enabled for scan.
  - On advance, ptr moves to the next enabled channel above the current one, wrapping, which skips masked channels.
  - On SCAN entry, ptr = lowest enabled channel.
  - If the current ptr channel is masked at capture time, it is skipped as on an advance, in the same cycle.
  - If mask_in = 0, no SCAN capture occurs and valid_out drains as in IDLE.
  - MAN mode ignores mask_in.
- Undefined: port absent; all channels scanned.

Decomposition:
- Package mux_pkg holds:
  - state enum (IDLE, MAN, SCAN);
  - mode constants MODE_MAN=1'b0, MODE_SCAN=1'b1.
- One sub-module, mux_scan_ptr, holds ptr, dwell cnt, wrap and (optional) mask skip.
  - Inputs: clear, step, mask.
  - Output: ptr.
- The top holds the FSM, output register and handshake.

Test Plan:
- Reset: N=4, WIDTH=8; assert rst_n_in=0 mid-beat -> valid_out, y_out, ch_out, err_out = 0 immediately.
- Manual mode: data_in=32'hDDCCBBAA, sel_in=2, ready_in=1 -> next cycle y_out=8'hCC, ch_out=2, valid_out=1, err_out=0.
- Out-of-range select: N=3, sel_in=3 -> y_out=0, ch_out=3, err_out=1.
- Scan mode, DWELL=2, ready_in=1: 8 beats -> ch_out sequence 0,0,1,1,2,2,3,3; ninth beat ch_out=0.
- Backpressure: ready_in=0 for 3 cycles while data_in and sel_in change -> y_out/ch_out stable and valid_out=1; after ready_in=1, scan resumes at the correct ptr with no channel skipped.
- MUX_SCAN_MASK_EN: mask_in=4'b1010 -> ch_out sequence 1,3,1,3; mask_in=0 -> valid_out drops after the last beat is accepted.
